// File: rtl/mul_result_buffer.sv
// Result buffer behind the sequential multiplier: captures one product per rising
// edge of mul_valid into a first-word-fall-through FIFO and keeps a running sum.
module mul_result_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int ACC_W = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2*N:0]               prodt_end,
  input  logic                       mul_valid,
  input  logic                       clr,
  output logic [2*N:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [ACC_W-1:0]           acc_sum
);

  localparam int PW = 2 * N + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             prev_valid_q;
  logic             overflow_q, overflow_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             cap, pop, push, drop;
  logic [ACC_W-1:0] prod_ext;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    cap      = mul_valid & ~prev_valid_q;
    pop      = ~empty_q & out_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    push     = cap & (~full_q | pop);
    drop     = cap & full_q & ~pop;
    prod_ext = ACC_W'(prodt_end);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    // A dropped capture wins over a simultaneous clear.
    overflow_d = overflow_q;
    if (drop)     overflow_d = 1'b1;
    else if (clr) overflow_d = 1'b0;

    acc_d = acc_q;
    if (clr)       acc_d = push ? prod_ext : '0;
    else if (push) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      prev_valid_q <= mul_valid;
      overflow_q   <= overflow_d;
      acc_q        <= acc_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/empty decide what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= prodt_end;
  end

  assign out_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign out_valid = ~empty_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign acc_sum   = acc_q;

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed bench for mul_result_buffer: stimulus pushes expected products into a
// queue, a negedge monitor pops and compares whenever the DUT hands one over.
module tb_mul_result_buffer;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int ACC_W = 24;
  localparam int PW    = 2 * N + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic [PW-1:0] prodt_end;
  logic          mul_valid;
  logic          clr;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [ACC_W-1:0] acc_sum;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  mul_result_buffer #(.N(N), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .prodt_end (prodt_end),
    .mul_valid (mul_valid),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .acc_sum   (acc_sum)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle mul_valid pulse followed by one low cycle.
  task automatic pulse(input logic [PW-1:0] p);
    prodt_end = p;
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " count"},     32'(count),     32'd0);
    check({tag, " empty"},     32'(empty),     32'd1);
    check({tag, " full"},      32'(full),      32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " overflow"},  32'(overflow),  32'd0);
    check({tag, " acc_sum"},   32'(acc_sum),   32'd0);
    check({tag, " out_data"},  32'(out_data),  32'd0);
  endtask

  // Scoreboard monitor: a pop happens on the next rising edge.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected pop", 32'(out_data), 32'hDEAD_BEEF);
      else                   check("pop data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b0;
    prodt_end = '0; mul_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;

    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      prodt_end = PW'($urandom);
      mul_valid = 1'($urandom);
      clr       = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    check_idle("reset");
    prodt_end = '0; mul_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Level held high for 5 cycles gives exactly one capture.
    prodt_end = 17'h09EB2;
    mul_valid = 1'b1;
    exp_q.push_back(17'h09EB2);
    tick();
    check("fwft count", 32'(count), 32'd1);
    check("fwft data", 32'(out_data), 32'h09EB2);
    for (int i = 0; i < 4; i++) tick();
    mul_valid = 1'b0;
    tick();
    check("held count", 32'(count), 32'd1);
    check("held data", 32'(out_data), 32'h09EB2);
    check("held acc", 32'(acc_sum), 32'h009EB2);

    pulse(17'h01572); exp_q.push_back(17'h01572);
    pulse(17'h07F77); exp_q.push_back(17'h07F77);
    pulse(17'h0EB44); exp_q.push_back(17'h0EB44);
    check("fill full", 32'(full), 32'd1);
    check("fill count", 32'(count), 32'd4);
    // 0x09EB2 + 0x01572 + 0x07F77 + 0x0EB44
    check("fill acc", 32'(acc_sum), 32'h021EDF);

    pulse(17'h00001);
    check("drop overflow", 32'(overflow), 32'd1);
    check("drop acc", 32'(acc_sum), 32'h021EDF);
    check("drop count", 32'(count), 32'd4);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    check("drain empty", 32'(empty), 32'd1);
    check("drain count", 32'(count), 32'd0);
    check("drain overflow sticky", 32'(overflow), 32'd1);

    // Clear together with an accepted capture.
    clr = 1'b1;
    prodt_end = 17'h07F77;
    mul_valid = 1'b1;
    exp_q.push_back(17'h07F77);
    tick();
    clr = 1'b0;
    mul_valid = 1'b0;
    check("clr+push acc", 32'(acc_sum), 32'h007F77);
    check("clr+push overflow", 32'(overflow), 32'd0);
    tick();

    pulse(17'h00022); exp_q.push_back(17'h00022);
    pulse(17'h00033); exp_q.push_back(17'h00033);
    pulse(17'h00044); exp_q.push_back(17'h00044);
    check("refill full", 32'(full), 32'd1);

    // Full FIFO, pop and capture on the same edge.
    out_ready = 1'b1;
    prodt_end = 17'h00005;
    mul_valid = 1'b1;
    exp_q.push_back(17'h00005);
    tick();
    out_ready = 1'b0;
    mul_valid = 1'b0;
    check("swap count", 32'(count), 32'd4);
    check("swap overflow", 32'(overflow), 32'd0);
    check("swap acc", 32'(acc_sum), 32'h008015);
    tick();

    // Clear together with a dropped capture: overflow ends set.
    clr = 1'b1;
    prodt_end = 17'h00100;
    mul_valid = 1'b1;
    tick();
    clr = 1'b0;
    mul_valid = 1'b0;
    check("clr+drop overflow", 32'(overflow), 32'd1);
    check("clr+drop acc", 32'(acc_sum), 32'd0);
    check("clr+drop count", 32'(count), 32'd4);
    tick();

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    check("drain2 empty", 32'(empty), 32'd1);

    // Reset mid-run with an entry held: clears without a clock edge.
    pulse(17'h00123);
    check("pre-reset count", 32'(count), 32'd1);
    reset = 1'b0;
    #2;
    exp_q.delete();
    check_idle("async reset");

    // mul_valid already high at reset release counts as a capture.
    prodt_end = 17'h00ABC;
    mul_valid = 1'b1;
    tick();
    reset = 1'b1;
    exp_q.push_back(17'h00ABC);
    tick();
    mul_valid = 1'b0;
    check("release capture count", 32'(count), 32'd1);
    check("release capture data", 32'(out_data), 32'h00ABC);
    check("release capture acc", 32'(acc_sum), 32'h000ABC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("final empty", 32'(empty), 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
